// File: rtl/mmio_pkg.sv
// mmio_pkg: register offsets, FSM state encoding and bit indices for mmio_responder
package mmio_pkg;
    localparam logic [31:0] BASE_ADDR = 32'hFFFF_0000;
    localparam logic [4:0] OFS_DISPA  = 5'h00;
    localparam logic [4:0] OFS_DISPB  = 5'h04;
    localparam logic [4:0] OFS_LED    = 5'h08;
    localparam logic [4:0] OFS_SW     = 5'h0C;
    localparam logic [4:0] OFS_TCOUNT = 5'h10;
    localparam logic [4:0] OFS_TCMP   = 5'h14;
    localparam logic [4:0] OFS_STATUS = 5'h18;
    localparam logic [4:0] OFS_CTRL   = 5'h1C;
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RESP = 1'b1;
    localparam int CTRL_EN     = 0;
    localparam int CTRL_CLR    = 1;
    localparam int STATUS_PEND = 0;
    function automatic logic in_window(input logic [31:0] a);
        return a[31:5] == BASE_ADDR[31:5];
    endfunction
endpackage

// File: rtl/mmio_timer.sv
// mmio_timer: free-running compare timer with sticky match flag
// Ports: clk/rst; en, clr_on_match from CTRL; tcmp_we/tcmp_wdata load TCMP;
//        status_clr clears pending; tcount, tcmp, pending are the register values.
module mmio_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr_on_match,
    input  logic        tcmp_we,
    input  logic [31:0] tcmp_wdata,
    input  logic        status_clr,
    output logic [31:0] tcount,
    output logic [31:0] tcmp,
    output logic        pending
);
    logic match;
    assign match = en && tcount == tcmp;
    always_ff @(posedge clk) begin
        if (rst) begin
            tcount  <= '0;
            tcmp    <= '0;
            pending <= 1'b0;
        end else begin
            if (tcmp_we) tcmp <= tcmp_wdata;
            if (en) tcount <= (match && clr_on_match) ? '0 : tcount + 32'd1;
            // a match in the same cycle as a clear keeps the flag set
            pending <= match | (pending & ~status_clr);
        end
    end
endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: memory-mapped display/LED/switch/timer registers with a one-cycle Ready handshake
// Ports: Clk, Rst (sync, active-high); Address/WriteData/MemWrite/MemRead CPU bus;
//        Switches raw input; ReadData/Hit/Ready bus responses; DisplayA/DisplayB/Leds/TimerIrq outputs.
// Define MMIO_TIMER_EN to build the timer, TCMP, STATUS and CTRL registers.
module mmio_responder
    import mmio_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [15:0] Switches,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        Ready,
    output logic [31:0] DisplayA,
    output logic [31:0] DisplayB,
    output logic [15:0] Leds,
    output logic        TimerIrq
);
    state_t      state;
    logic [15:0] sw_meta, sw_sync;
    logic [31:0] rd_next, timer_rd;
    logic [4:0]  ofs;
    logic        accept, wr_ok;
    assign Hit    = in_window(Address);
    assign accept = state == ST_IDLE && Hit && (MemRead || MemWrite);
    assign ofs    = {Address[4:2], 2'b00};
    assign wr_ok  = accept && MemWrite && Address[1:0] == 2'b00;
    assign Ready  = state == ST_RESP;
`ifdef MMIO_TIMER_EN
    logic [1:0]  ctrl;
    logic [31:0] tcount, tcmp;
    logic        pending;
    mmio_timer u_timer (
        .clk         (Clk),
        .rst         (Rst),
        .en          (ctrl[CTRL_EN]),
        .clr_on_match(ctrl[CTRL_CLR]),
        .tcmp_we     (wr_ok && ofs == OFS_TCMP),
        .tcmp_wdata  (WriteData),
        .status_clr  (wr_ok && ofs == OFS_STATUS && WriteData[STATUS_PEND]),
        .tcount      (tcount),
        .tcmp        (tcmp),
        .pending     (pending)
    );
    always_ff @(posedge Clk) begin
        if (Rst) ctrl <= '0;
        else if (wr_ok && ofs == OFS_CTRL) ctrl <= WriteData[1:0];
    end
    assign TimerIrq = pending;
    assign timer_rd = ofs == OFS_TCOUNT ? tcount :
                      ofs == OFS_TCMP   ? tcmp :
                      ofs == OFS_STATUS ? {31'h0, pending} :
                      ofs == OFS_CTRL   ? {30'h0, ctrl} : '0;
`else
    assign TimerIrq = 1'b0;
    assign timer_rd = '0;
`endif
    // writes (including write+read) and unaligned accesses return 0
    assign rd_next = (MemWrite || Address[1:0] != 2'b00) ? '0 :
                     ofs == OFS_DISPA ? DisplayA :
                     ofs == OFS_DISPB ? DisplayB :
                     ofs == OFS_LED   ? {16'h0, Leds} :
                     ofs == OFS_SW    ? {16'h0, sw_sync} : timer_rd;
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= ST_IDLE;
            ReadData <= '0;
            DisplayA <= '0;
            DisplayB <= '0;
            Leds     <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            state    <= accept ? ST_RESP : ST_IDLE;
            ReadData <= accept ? rd_next : '0;
            sw_meta  <= Switches;
            sw_sync  <= sw_meta;
            if (wr_ok && ofs == OFS_DISPA) DisplayA <= WriteData;
            if (wr_ok && ofs == OFS_DISPB) DisplayB <= WriteData;
            if (wr_ok && ofs == OFS_LED) Leds <= WriteData[15:0];
        end
    end
endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped I/O responder on the datapath's data-memory bus: decodes a fixed address window, answers CPU loads and stores with a one-cycle Ready handshake, and owns the display, LED, switch, and timer registers. It sits beside DataMemory on the same Address/WriteData/MemWrite/MemRead lines. The top-level steers ReadData from this block instead of DataMemory when Hit is high.

## Interface
- BASE_ADDR, 32'hFFFF_0000: base of the 32-byte register window (aligned to 32 bytes).
- Clk  in  1  system clock (the divided CPU clock); all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- Address  in  32  CPU byte address.
- WriteData  in  32  store data.
- MemWrite  in  1  store request.
- MemRead  in  1  load request.
- Switches  in  16  raw board switches (asynchronous).
- ReadData  out  32  load data; valid when Ready=1.
- Hit  out  1  combinational: Address[31:5]==BASE_ADDR[31:5].
- Ready  out  1  access complete this cycle.
- DisplayA  out  32  value for the display's left 4 digits.
- DisplayB  out  32  value for the display's right 4 digits.
- Leds  out  16  LED drive.
- TimerIrq  out  1  timer match pending.

## Operation
- Register map (offset, byte): 0x00 DISPA RW; 0x04 DISPB RW; 0x08 LED RW, bits 15:0, upper bits read 0; 0x0C SW RO, zero-extended; 0x10 TCOUNT RO; 0x14 TCMP RW; 0x18 STATUS, bit0 = irq pending, write 1 to clear; 0x1C CTRL, bit0 = timer enable, bit1 = clear count on match.
- Request: Hit & (MemRead | MemWrite). When both are asserted, the access is a write and the read returns 0.
- FSM with two states, IDLE and RESP. From IDLE, a request moves to RESP and latches the offset. RESP always returns to IDLE.
- The CPU holds the request through RESP. A request seen in RESP is not re-accepted.
- Writes commit on the IDLE→RESP edge. Read data is registered on the same edge.
- In RESP: Ready=1, and ReadData holds the latched read, or 0 for a write.
- Unaligned accesses (Address[1:0]≠0) and reserved offsets: writes are ignored, reads return 0. Ready still pulses.
- Switches pass through a two-flop synchronizer. SW reads return the synchronized value.
- Timer, when CTRL.bit0=1:
  - TCOUNT increments every cycle and wraps 0xFFFF_FFFF→0.
  - When TCOUNT==TCMP, pending is set. If CTRL.bit1=1, TCOUNT loads 0 on the next cycle instead of incrementing.
  - If a match and a STATUS clear land in the same cycle, set wins.
  - Writing TCMP does not change TCOUNT.
- TimerIrq = pending.

## Timing
- Reset values: every register 0, FSM in IDLE, Ready=0, ReadData=0, synchronizer flops 0.
- Access latency is 2 cycles: request cycle, then a RESP cycle with Ready=1.
- Back-to-back requests: IDLE, RESP, IDLE, RESP. Maximum rate is one access per 2 cycles.
- A read of TCOUNT returns the value present in the request cycle.
- Switch-to-SW-read latency is 2 cycles.
- Rst asserted mid-access aborts it: no write commits if Rst is high on that edge, and the next state is IDLE.

## Configuration
- MMIO_TIMER_EN defined: the timer, TCMP, STATUS, and CTRL are implemented as specified above.
- MMIO_TIMER_EN undefined:
  - TCOUNT, TCMP, STATUS, and CTRL read 0; writes to them are ignored.
  - TimerIrq is tied to 0 and no timer flops are synthesized.

## Structure
- Package mmio_pkg holds:
  - register offset constants (OFS_DISPA … OFS_CTRL);
  - the FSM state typedef (ST_IDLE, ST_RESP);
  - CTRL and STATUS bit index constants.
- Sub-module mmio_timer holds TCOUNT, TCMP, pending, and the match/clear logic. It is instantiated only under MMIO_TIMER_EN.

## Test plan
- Reset, then store 0x1234_5678 to BASE+0x00 → Ready=1 the next cycle; DisplayA=0x1234_5678 after that edge. Load BASE+0x00 → ReadData=0x1234_5678 with Ready.
- Store 0xABCD_FFFF to BASE+0x08 → Leds=0xFFFF. Load → ReadData=0x0000_FFFF.
- Drive Switches=0x00A5 → a load of BASE+0x0C issued 2+ cycles later returns 0x0000_00A5. Load BASE+0x03 (unaligned) → ReadData=0, Ready=1, no state change.
- Write TCMP=5, then CTRL=3 → TimerIrq rises when TCOUNT==5, and TCOUNT returns to 0. Write STATUS=1 in the same cycle as the next match → TimerIrq stays 1.
- Address outside the window (0x0000_0010) with MemWrite → Hit=0, Ready stays 0, no register changes. Rst during the request cycle of a store to DISPB → DisplayB remains 0.
